// File: rtl/tt_cpu_pkg.sv
`default_nettype none
// Shared definitions for the 6-bit microcoded CPU: bus widths, opcodes and the
// built-in default program that the program memory restores on reset.
package tt_cpu_pkg;

  localparam int AW    = 6;
  localparam int DW    = 6;
  localparam int DEPTH = 1 << AW;

  localparam logic [DW-1:0] OP_ADD  = 6'd1;
  localparam logic [DW-1:0] OP_SWAP = 6'd2;
  localparam logic [DW-1:0] OP_LDC  = 6'd3;
  localparam logic [DW-1:0] OP_STC  = 6'd4;
  localparam logic [DW-1:0] OP_JMP  = 6'd5;
  localparam logic [DW-1:0] OP_JZ   = 6'd6;
  localparam logic [DW-1:0] OP_LDI  = 6'd7;
  localparam logic [DW-1:0] OP_INC  = 6'd8;
  localparam logic [DW-1:0] OP_NOT  = 6'd9;
  localparam logic [DW-1:0] OP_OUT  = 6'd16;

  // Mixed opcode/operand stream; plain literals are operand words.
  localparam logic [DW-1:0] DEFAULT_PROG [DEPTH] = '{
    0:  OP_ADD,
    1:  OP_SWAP,
    2:  OP_OUT,
    3:  OP_JZ,
    4:  6'd0,
    5:  OP_LDI,
    6:  6'd63,
    7:  OP_STC,
    8:  6'd1,
    9:  OP_LDC,
    10: OP_NOT,
    11: OP_INC,
    12: OP_JMP,
    13: 6'd7,
    default: 6'd0
  };

  function automatic logic [DW-1:0] default_word(input logic [AW-1:0] addr);
    return DEFAULT_PROG[addr];
  endfunction

endpackage : tt_cpu_pkg
`default_nettype wire

// File: rtl/prog_mem_regs.sv
`default_nettype none
// 64x6 program storage: resets to the default program, one synchronous write
// port and one asynchronous read port.
module prog_mem_regs
  import tt_cpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DW'(default_word(tt_cpu_pkg::AW'(i)));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : prog_mem_regs
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// Program memory for the 6-bit CPU with a valid/ready host load port; the CPU is
// held in reset (cpu_hold) while a new program is streamed in.
module prog_mem_loader
  import tt_cpu_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_hold,
  input  logic          load_req,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [AW:0]   load_count
);

  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          req_prev;
  logic [CW-1:0] count;
  logic          start;
  logic          accept;
  logic          last_word;
  logic [DW-1:0] rdata;

  // req_prev resets high so a request already asserted at reset release is
  // not mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_prev <= 1'b1;
      count    <= '0;
    end else begin
      state    <= state_next;
      req_prev <= load_req;
      if (start) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end
    end
  end

  assign accept    = load_valid & load_ready;
  assign last_word = accept && (count == CW'(DEPTH - 1));

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    start      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_req && !req_prev) begin
          start      = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        cpu_hold   = 1'b1;
        // A word arriving with load_req low is still written before exiting.
        if (last_word || !load_req) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_hold   = 1'b1;
        load_done  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  prog_mem_regs #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_regs (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (count[AW-1:0]),
    .wdata (load_data),
    .raddr (cpu_addr),
    .rdata (rdata)
  );

  assign cpu_data   = cpu_hold ? '0 : rdata;
  assign load_count = count;

endmodule : prog_mem_loader
`default_nettype wire
